// File: rtl/fetch_stream_injector_pkg.sv
// Shared types for the fetch->decode stimulus injector: Axis payload and FSM state.
package fetch_stream_injector_pkg;

   localparam int PC_WIDTH    = 32;
   localparam int INSTR_WIDTH = 32;

   typedef logic [INSTR_WIDTH-1:0] instruction_t;

   typedef struct packed {
      logic [PC_WIDTH-1:0] program_counter;
      instruction_t        instruction;
   } fetch_to_decode_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } injector_state_t;

endpackage

// File: rtl/fetch_stream_injector_if.sv
// Axis fetch->decode link and single-port instruction SRAM, one modport pair per side.
interface fetch_stream_injector_if
   import fetch_stream_injector_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) ();

   fetch_to_decode_t        tdata;
   logic                    tvalid;
   logic                    tready;

   logic [ADDR_WIDTH-1:0]   address;
   logic                    read_enable;
   instruction_t            read_data;

   modport axis_master (output tdata, output tvalid, input tready);
   modport axis_slave  (input tdata, input tvalid, output tready);
   modport sram_master (output address, output read_enable, input read_data);
   modport sram_slave  (input address, input read_enable, output read_data);

endinterface

// File: rtl/fetch_stream_injector_sync_fifo2.sv
// Two-entry response buffer between SRAM read data and the Axis output; zero-latency head.
// Push and pop may coincide; clear_i empties it on the next edge.
module sync_fifo2
   import fetch_stream_injector_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  fetch_to_decode_t data_i,
   output fetch_to_decode_t head_o,
   output logic [1:0]       count_o
);

   fetch_to_decode_t mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;

   always_comb begin
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (clear_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // The injector's credit check must make a push into a full buffer impossible.
   assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !clear_i && count_q == 2'd2));

endmodule

// File: rtl/fetch_stream_injector.sv
// Reads a block of instruction words from SRAM and streams {PC, word} onto Axis toward decode.
// First word 2 cycles after start, then 1 word/cycle; reads throttle so the 2-entry buffer never overflows.
module fetch_stream_injector
   import fetch_stream_injector_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   flush,
   input  logic [ADDR_WIDTH-1:0]  base_address,
   input  logic [COUNT_WIDTH-1:0] word_count,
   output logic                   busy,
   output logic                   done,
   fetch_stream_injector_if.axis_master axis_fetch_to_decode,
   fetch_stream_injector_if.sram_master sramport_instr
);

   injector_state_t        state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [COUNT_WIDTH-1:0] issued_q, issued_d;
   logic [COUNT_WIDTH-1:0] accepted_q, accepted_d;
   logic                   done_q, done_d;
   logic                   inflight_q;
   logic [ADDR_WIDTH-1:0]  inflight_pc_q;

   logic                   read_en;
   logic                   pop;
   logic [2:0]             occupancy;
   logic [1:0]             fifo_count;
   fetch_to_decode_t       fifo_head;
   fetch_to_decode_t       fifo_in;

   assign pop = (fifo_count != 2'd0) && axis_fetch_to_decode.tready;

   // Entries held plus the one read still in flight, minus the one leaving this cycle.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign read_en   = (state_q == RUN) && (issued_q != count_q)
                      && (occupancy < 3'(FIFO_DEPTH)) && !flush;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      issued_d   = issued_q;
      accepted_d = accepted_q;
      done_d     = 1'b0;

      if (read_en) begin
         addr_d   = addr_q + ADDR_WIDTH'(4);
         issued_d = issued_q + COUNT_WIDTH'(1);
      end
      if (pop) begin
         accepted_d = accepted_q + COUNT_WIDTH'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (start && !flush) begin
               addr_d     = {base_address[ADDR_WIDTH-1:2], 2'b00};
               count_d    = word_count;
               issued_d   = '0;
               accepted_d = '0;
               if (word_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (issued_d == count_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && accepted_d == count_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d    = IDLE;
         done_d     = 1'b0;
         issued_d   = '0;
         accepted_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         count_q       <= '0;
         issued_q      <= '0;
         accepted_q    <= '0;
         done_q        <= 1'b0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         issued_q   <= issued_d;
         accepted_q <= accepted_d;
         done_q     <= done_d;
         inflight_q <= read_en;
         if (read_en) begin
            inflight_pc_q <= addr_q;
         end
      end
   end

   always_comb begin
      fifo_in                 = '0;
      fifo_in.program_counter = PC_WIDTH'(inflight_pc_q);
      fifo_in.instruction     = sramport_instr.read_data;
   end

   sync_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (inflight_q && !flush),
      .pop_i   (pop),
      .clear_i (flush),
      .data_i  (fifo_in),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   assign axis_fetch_to_decode.tvalid = (fifo_count != 2'd0);
   assign axis_fetch_to_decode.tdata  = fifo_head;
   assign sramport_instr.address      = addr_q;
   assign sramport_instr.read_enable  = read_en;
   assign busy                        = (state_q != IDLE);
   assign done                        = done_q;

endmodule

// File: tb/tb_fetch_stream_injector.sv
// Directed bench for fetch_stream_injector: queued expectations checked by a negedge monitor.
module tb_fetch_stream_injector;
   import fetch_stream_injector_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] base_address = '0;
   logic [15:0] word_count = '0;
   logic        busy;
   logic        done;

   fetch_stream_injector_if #(.ADDR_WIDTH(32)) link ();

   fetch_stream_injector dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .flush                (flush),
      .base_address         (base_address),
      .word_count           (word_count),
      .busy                 (busy),
      .done                 (done),
      .axis_fetch_to_decode (link),
      .sramport_instr       (link)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   fetch_to_decode_t exp_q[$];
   logic [31:0]      exp_rd_q[$];
   int               read_cyc[$];
   int               hs_cyc[$];
   int               reads, hs, tv_cnt, done_cnt, done_cyc, start_cyc;
   bit               prev_stall = 1'b0;
   fetch_to_decode_t prev_dat;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0100: mem_word = 32'h0050_0093;
         32'h0000_0104: mem_word = 32'h00A0_0113;
         32'h0000_0108: mem_word = 32'h0020_81B3;
         32'h0000_010C: mem_word = 32'h4011_0233;
         default:       mem_word = a ^ 32'h5A5A_A5A5;
      endcase
   endfunction

   // SRAM model: data valid the cycle after read_enable.
   initial link.read_data = '0;
   always @(posedge clk) if (link.read_enable) link.read_data <= mem_word(link.address);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      qget = (i < q.size()) ? q[i] : -1;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (link.read_enable) begin
            reads++;
            read_cyc.push_back(cyc);
            if (exp_rd_q.size() == 0) chk("unexpected_read", {32'd0, link.address}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("read_addr", {32'd0, link.address}, {32'd0, exp_rd_q.pop_front()});
         end
         if (link.tvalid) tv_cnt++;
         if (prev_stall) begin
            chk("stall_tvalid_hold", {63'd0, link.tvalid}, 64'd1);
            chk("stall_tdata_hold", link.tdata, prev_dat);
         end
         if (link.tvalid && link.tready) begin
            hs++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_handshake", link.tdata, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("handshake_data", link.tdata, exp_q.pop_front());
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_with_busy", {63'd0, busy}, 64'd0);
         end
         prev_stall = link.tvalid && !link.tready && !flush;
         prev_dat   = link.tdata;
      end
   end

   task automatic clear_stats();
      reads = 0; hs = 0; tv_cnt = 0; done_cnt = 0; done_cyc = -1;
      read_cyc.delete();
      hs_cyc.delete();
   endtask

   task automatic start_run(input logic [31:0] b, input int n);
      @(posedge clk); #1;
      base_address = b;
      word_count   = 16'(n);
      start        = 1'b1;
      start_cyc    = cyc;
      for (int i = 0; i < n; i++) begin
         logic [31:0] pc;
         fetch_to_decode_t e;
         pc = b + 32'(4 * i);
         e.program_counter = pc;
         e.instruction     = mem_word(pc);
         exp_q.push_back(e);
         exp_rd_q.push_back(pc);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk(name, {63'd0, seen}, 64'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_done"}, {63'd0, done}, 64'd0);
      chk({tag, "_tvalid"}, {63'd0, link.tvalid}, 64'd0);
      chk({tag, "_read_enable"}, {63'd0, link.read_enable}, 64'd0);
      chk({tag, "_address"}, {32'd0, link.address}, 64'd0);
      chk({tag, "_tdata"}, link.tdata, 64'd0);
   endtask

   task automatic run_basic(input string tag);
      clear_stats();
      link.tready = 1'b1;
      start_run(32'h100, 4);
      wait_done({tag, "_done_seen"}, 40);
      repeat (3) @(negedge clk);
      chk({tag, "_reads"}, 64'(reads), 64'd4);
      chk({tag, "_first_read_cyc"}, 64'(qget(read_cyc, 0)), 64'(start_cyc + 1));
      chk({tag, "_last_read_cyc"}, 64'(qget(read_cyc, 3)), 64'(start_cyc + 4));
      chk({tag, "_handshakes"}, 64'(hs), 64'd4);
      chk({tag, "_first_hs_cyc"}, 64'(qget(hs_cyc, 0)), 64'(start_cyc + 3));
      chk({tag, "_last_hs_cyc"}, 64'(qget(hs_cyc, 3)), 64'(start_cyc + 6));
      chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(start_cyc + 7));
      chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      bit got;
      link.tready = 1'b1;
      clear_stats();

      #2;
      check_idle_outputs("reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      run_basic("basic");

      // Backpressure: tready low for 5 cycles after the first tvalid.
      clear_stats();
      link.tready = 1'b0;
      start_run(32'h0, 3);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (link.tvalid) got = 1'b1;
      end
      chk("stall_tvalid_seen", {63'd0, got}, 64'd1);
      repeat (5) @(negedge clk);
      chk("stall_reads_max2", {63'd0, reads <= 2}, 64'd1);
      chk("stall_pc", {32'd0, link.tdata.program_counter}, 64'd0);
      chk("stall_no_handshake", 64'(hs), 64'd0);
      @(posedge clk); #1;
      link.tready = 1'b1;
      wait_done("stall_done_seen", 40);
      repeat (2) @(negedge clk);
      chk("stall_handshakes", 64'(hs), 64'd3);
      chk("stall_exp_left", 64'(exp_q.size()), 64'd0);

      // Zero-length run.
      clear_stats();
      start_run(32'h40, 0);
      @(negedge clk);
      chk("zero_done", {63'd0, done}, 64'd1);
      chk("zero_busy", {63'd0, busy}, 64'd0);
      repeat (4) @(negedge clk);
      chk("zero_reads", 64'(reads), 64'd0);
      chk("zero_tvalid", 64'(tv_cnt), 64'd0);
      chk("zero_done_count", 64'(done_cnt), 64'd1);

      // Address wrap at the top of the space.
      clear_stats();
      start_run(32'hFFFF_FFF8, 4);
      wait_done("wrap_done_seen", 40);
      repeat (2) @(negedge clk);
      chk("wrap_handshakes", 64'(hs), 64'd4);
      chk("wrap_exp_left", 64'(exp_q.size()), 64'd0);

      // Flush two cycles into a stalled run.
      clear_stats();
      link.tready = 1'b0;
      start_run(32'h300, 8);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_tvalid", {63'd0, link.tvalid}, 64'd0);
      chk("flush_busy", {63'd0, busy}, 64'd0);
      chk("flush_done", {63'd0, done}, 64'd0);
      chk("flush_read_enable", {63'd0, link.read_enable}, 64'd0);
      exp_q.delete();
      exp_rd_q.delete();
      repeat (4) @(negedge clk);
      chk("flush_no_done", 64'(done_cnt), 64'd0);
      chk("flush_no_tvalid", 64'(tv_cnt), 64'd0);
      clear_stats();
      link.tready = 1'b1;
      start_run(32'h200, 1);
      wait_done("post_flush_done_seen", 40);
      repeat (2) @(negedge clk);
      chk("post_flush_handshakes", 64'(hs), 64'd1);
      chk("post_flush_exp_left", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset in the middle of a run.
      clear_stats();
      start_run(32'h500, 6);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      #1 check_idle_outputs("async_reset");
      exp_q.delete();
      exp_rd_q.delete();
      @(posedge clk); #2;
      rst = 1'b1;
      run_basic("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
